// File: rtl/fsm_share_arbiter_if.sv
// Bundle of requester-side and mealy_fsm-side signals around fsm_share_arbiter.
// master = requesters plus the shared FSM's output; slave = the arbiter.
interface fsm_share_arbiter_if #(
    parameter int NREQ      = 4,
    parameter int BURST_MAX = 8,
    parameter int LW        = $clog2(BURST_MAX + 1)
);
    logic [NREQ-1:0]    req;
    logic [2*NREQ-1:0]  req_x;
    logic [LW*NREQ-1:0] req_len;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    sym_ack;
    logic [NREQ-1:0]    done;
    logic               aborted;
    logic               busy;
    logic               fsm_en;
    logic [1:0]         fsm_x;
    logic               fsm_clr;
    logic               fsm_y_out;
    logic               rsp_valid;
    logic               rsp_y_out;

    modport master (
        output req, req_x, req_len, fsm_y_out,
        input  gnt, sym_ack, done, aborted, busy, fsm_en, fsm_x, fsm_clr,
               rsp_valid, rsp_y_out
    );

    modport slave (
        input  req, req_x, req_len, fsm_y_out,
        output gnt, sym_ack, done, aborted, busy, fsm_en, fsm_x, fsm_clr,
               rsp_valid, rsp_y_out
    );
endinterface

// File: rtl/fsm_share_arbiter.sv
// Round-robin owner of one shared mealy_fsm: a winner streams up to BURST_MAX
// symbols through it, then a one-cycle GAP returns done and optionally clears the FSM.
module fsm_share_arbiter #(
    parameter int NREQ          = 4,
    parameter int BURST_MAX     = 8,
    parameter int LW            = $clog2(BURST_MAX + 1),
    parameter int CLR_ON_SWITCH = 1
) (
    input  logic                clk,
    input  logic                rst,
    fsm_share_arbiter_if.slave  bus
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, RUN, GAP} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   own_q, own_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            abort_q, abort_d;

    logic [LW-1:0]   len_arr [NREQ];
    logic [1:0]      x_arr   [NREQ];
    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand;
    logic            own_req;
    logic            run_live;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign len_arr[g] = bus.req_len[g*LW +: LW];
        assign x_arr[g]   = bus.req_x[2*g +: 2];
    end

    function automatic logic [LW-1:0] eff_len(input logic [LW-1:0] len);
        if (len == '0) return LW'(1);
        if (len > LW'(BURST_MAX)) return LW'(BURST_MAX);
        return len;
    endfunction

    // Scan ptr+1, ptr+2, ... so the previous owner is always considered last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IW'((int'(ptr_q) + i) % NREQ);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign own_req  = bus.req[own_q];
    assign run_live = (state_q == RUN) && own_req;

    // NOTE: every variable gets a default at the top of a combinational block so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        abort_d = abort_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d          = RUN;
                    own_d            = win_idx;
                    cnt_d            = eff_len(len_arr[win_idx]);
                    gnt_d            = '0;
                    gnt_d[win_idx]   = 1'b1;
                    abort_d          = 1'b0;
                end
            end
            RUN: begin
                if (!own_req) begin
                    state_d = GAP;
                    gnt_d   = '0;
                    abort_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - LW'(1);
                    if (cnt_q == LW'(1)) begin
                        state_d = GAP;
                        gnt_d   = '0;
                    end
                end
            end
            GAP: begin
                state_d = IDLE;
                ptr_d   = own_q;
                abort_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            own_q   <= '0;
            ptr_q   <= IW'(NREQ - 1);
            cnt_q   <= '0;
            gnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            abort_q <= abort_d;
        end
    end

    // Outputs decode from registered state, so reset drops them without an edge.
    always_comb begin
        bus.sym_ack = '0;
        bus.done    = '0;
        if (run_live)         bus.sym_ack[own_q] = 1'b1;
        if (state_q == GAP)   bus.done[own_q]    = 1'b1;
        bus.gnt       = gnt_q;
        bus.fsm_en    = run_live;
        bus.fsm_x     = (state_q == RUN) ? x_arr[own_q] : 2'b00;
        bus.rsp_valid = run_live;
        bus.rsp_y_out = run_live & bus.fsm_y_out;
        bus.aborted   = (state_q == GAP) && abort_q;
        bus.fsm_clr   = (state_q == GAP) && (CLR_ON_SWITCH != 0);
        bus.busy      = (state_q != IDLE);
    end
endmodule

// File: doc/fsm_share_arbiter.md
Name: fsm_share_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one mealy_fsm instance (en, x[1:0], y_out) among NREQ requesters.
- The winner owns the FSM for a burst of up to BURST_MAX symbols. The arbiter drives fsm_en/fsm_x from the winner's symbol port and routes fsm_y_out back to it.
- Between owners it optionally pulses a clear so each burst starts from the FSM reset state.

Parameters:
- NREQ, 4, number of requesters (2..8).
- BURST_MAX, 8, max symbols per grant.
- LW, $clog2(BURST_MAX+1), width of each length field.
- CLR_ON_SWITCH, 1, 1 = pulse fsm_clr in the GAP cycle after every burst.

Ports:
- clk  in  1  system clock, all flops rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req  in  NREQ  per-requester request, held high until done.
- req_x  in  2*NREQ  symbol of requester i at [2i+1:2i].
- req_len  in  LW*NREQ  burst length of requester i at [LW*i+LW-1:LW*i].
- gnt  out  NREQ  one-hot grant, registered.
- sym_ack  out  NREQ  per-requester "symbol consumed this edge".
- done  out  NREQ  one-cycle burst-complete pulse to the owner.
- aborted  out  1  qualifies done: burst ended by req drop.
- busy  out  1  state != IDLE.
- fsm_en  out  1  to mealy_fsm en.
- fsm_x  out  2  to mealy_fsm x.
- fsm_clr  out  1  to mealy_fsm reset (active-high pulse).
- fsm_y_out  in  1  from mealy_fsm y_out.
- rsp_valid  out  1  rsp_y_out is valid this cycle.
- rsp_y_out  out  1  fsm_y_out routed to the owner.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; gnt=0, done=0, aborted=0, fsm_en=0, fsm_clr=0, sym_ack=0, rsp_valid=0, fsm_x=0.
  - ptr=NREQ-1, so requester 0 has first priority. cnt=0.
  - Reset asserted mid-burst drops fsm_en immediately, with no done pulse.
- States: IDLE, RUN, GAP.
- IDLE:
  - On an edge with |req, pick the first asserted index scanning ptr+1, ptr+2, ... mod NREQ.
  - At that edge: gnt<=onehot(win), own<=win, cnt<=eff_len(win), state<=RUN.
  - Grant latency: 1 cycle from the first sampled req.
- eff_len rules:
  - len=0 → 1.
  - len>BURST_MAX → BURST_MAX.
  - Otherwise len.
  - Length is latched at grant; later changes to req_len are ignored.
- RUN (combinational outputs from state/own):
  - fsm_en=1; fsm_x=req_x[own]; sym_ack[own]=1.
  - rsp_valid=1; rsp_y_out=fsm_y_out. These are same-cycle Mealy outputs for the current x.
- RUN, each edge:
  - cnt decrements.
  - If cnt==1 at the edge → state<=GAP.
  - If req[own]==0 sampled in RUN → abort: that cycle still drives fsm_en=0 (masked), sym_ack=0, rsp_valid=0, and state<=GAP with aborted flag set.
- GAP (exactly 1 cycle):
  - gnt=0; done[own]=1; aborted = abort flag; fsm_en=0.
  - fsm_clr=CLR_ON_SWITCH.
  - ptr<=own; state<=IDLE.
- Throughput:
  - A burst of L symbols occupies L RUN cycles + 1 GAP cycle + ≥1 IDLE cycle.
  - Back-to-back owners: gnt edges are L+2 cycles apart.
- Fairness:
  - The owner cannot win the next arbitration if any other req is high.
  - A sole requester may re-win after GAP+IDLE.
- Simultaneous events:
  - New reqs arriving during RUN/GAP wait; they are arbitrated in IDLE only.
  - req dropping on the same edge the last symbol completes counts as normal completion (aborted=0).
- Invariants:
  - gnt is at most one-hot.
  - sym_ack ⊆ gnt.
  - fsm_en implies popcount(gnt)==1.
  - done is never asserted while fsm_en=1.

Test Plan:
- Reset then req=4'b0001, len0=3, x0 held 2'd0 → gnt=0001 one cycle later; fsm_en high exactly 3 cycles; sym_ack[0] 3 pulses; done[0] + fsm_clr 1 cycle; aborted=0; busy low after.
- req=4'b1111, all len=1 → grants in order 0,1,2,3,0, each gnt edge 3 cycles apart; never two bits in gnt.
- Requester 2 alone, len=0 then len=15 → 1 symbol, then 8 symbols (clamp to BURST_MAX).
- Requester 1 len=5, drop req[1] after 2 symbols → fsm_en=0 that cycle; GAP with done[1]=1, aborted=1; requester 3 (pending) granted next.
- Force fsm_y_out pattern 1,0,1 during a 3-symbol burst → rsp_valid=1 and rsp_y_out=1,0,1 in the same cycles; rsp_valid=0 in GAP/IDLE.
- rst=0 asserted mid-RUN → fsm_en, gnt, sym_ack low without a clock edge; after release, requester 0 has priority again.
